// File: rtl/hazard_if.sv
// Pipeline-side view of the hazard controller: decode/EX/MEM/WB status in,
// stall/flush/bubble/forwarding controls out.
interface hazard_if;
  logic       dec_valid;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       dec_use_rs1;
  logic       dec_use_rs2;
  logic       ex_valid;
  logic       ex_is_load;
  logic [4:0] ex_rd;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic       ex_redirect;
  logic       mem_reg_write;
  logic [4:0] mem_rd;
  logic       mem_req;
  logic       mem_ready;
  logic       wb_reg_write;
  logic [4:0] wb_rd;

  logic       if_stall;
  logic       id_stall;
  logic       ex_stall;
  logic       mem_stall;
  logic       id_flush;
  logic       ex_bubble;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       mem_timeout;

  // Pipeline datapath side.
  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           ex_valid, ex_is_load, ex_rd, ex_rs1, ex_rs2, ex_redirect,
           mem_reg_write, mem_rd, mem_req, mem_ready, wb_reg_write, wb_rd,
    input  if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_bubble,
           fwd_a_sel, fwd_b_sel, mem_timeout
  );

  // Hazard controller side.
  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           ex_valid, ex_is_load, ex_rd, ex_rs1, ex_rs2, ex_redirect,
           mem_reg_write, mem_rd, mem_req, mem_ready, wb_reg_write, wb_rd,
    output if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_bubble,
           fwd_a_sel, fwd_b_sel, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// Define HAZARD_PERF_EN to add 32-bit load-use / memory-stall / flush counters.
module hazard_ctrl #(
  parameter int REDIRECT_PENALTY = 1,
  parameter int MEM_TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  hazard_if.slave     hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_ldu_stalls,
  output logic [31:0] perf_mem_stalls,
  output logic [31:0] perf_flushes
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(MEM_TIMEOUT);
  localparam logic [2:0]  EXTRA_C   = 3'(REDIRECT_PENALTY - 1);

  state_t      state;
  state_t      ret_state;
  logic [15:0] wait_cnt;
  logic [2:0]  redir_cnt;
  logic        timeout_q;

  logic   mem_busy;
  logic   redirect;
  logic   in_redirect;
  logic   ldu_hit;
  logic   load_use;
  state_t eff_state;

  // Once memory answers, the cycle behaves as the state we were parked from.
  assign eff_state = (state == MEM_WAIT) ? ret_state : state;

  assign mem_busy    = hz.mem_req & ~hz.mem_ready;
  assign redirect    = ~mem_busy & hz.ex_valid & hz.ex_redirect;
  assign in_redirect = ~mem_busy & ~redirect & (eff_state == REDIRECT);
  assign ldu_hit     = hz.ex_valid & hz.ex_is_load & (hz.ex_rd != 5'd0) & hz.dec_valid &
                       ((hz.dec_use_rs1 & (hz.dec_rs1 == hz.ex_rd)) |
                        (hz.dec_use_rs2 & (hz.dec_rs2 == hz.ex_rd)));
  assign load_use    = ~mem_busy & ~redirect & (eff_state == RUN) & ldu_hit;

  assign hz.if_stall    = mem_busy | load_use;
  assign hz.id_stall    = mem_busy | load_use;
  assign hz.ex_stall    = mem_busy;
  assign hz.mem_stall   = mem_busy;
  assign hz.id_flush    = redirect | in_redirect;
  assign hz.ex_bubble   = redirect | load_use;
  assign hz.mem_timeout = timeout_q;

  // MEM result wins over WB; x0 is never forwarded.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    hz.fwd_a_sel = 2'b00;
    hz.fwd_b_sel = 2'b00;
    if (hz.mem_reg_write && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs1)
      hz.fwd_a_sel = 2'b01;
    else if (hz.wb_reg_write && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rs1)
      hz.fwd_a_sel = 2'b10;
    if (hz.mem_reg_write && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs2)
      hz.fwd_b_sel = 2'b01;
    else if (hz.wb_reg_write && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rs2)
      hz.fwd_b_sel = 2'b10;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      ret_state <= RUN;
      wait_cnt  <= '0;
      redir_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (mem_busy) begin
        state <= MEM_WAIT;
        if (state != MEM_WAIT) ret_state <= state;
        if (wait_cnt != TIMEOUT_C) wait_cnt <= wait_cnt + 16'd1;
        if (wait_cnt >= TIMEOUT_C - 16'd1) timeout_q <= 1'b1;
      end else begin
        wait_cnt  <= '0;
        ret_state <= RUN;
        if (redirect) begin
          // The flush cycle itself counts toward the penalty.
          state     <= (EXTRA_C != 3'd0) ? REDIRECT : RUN;
          redir_cnt <= EXTRA_C;
        end else if (eff_state == REDIRECT) begin
          state     <= (redir_cnt <= 3'd1) ? RUN : REDIRECT;
          redir_cnt <= (redir_cnt == 3'd0) ? 3'd0 : redir_cnt - 3'd1;
        end else begin
          state     <= RUN;
          redir_cnt <= '0;
        end
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_ldu_stalls <= '0;
      perf_mem_stalls <= '0;
      perf_flushes    <= '0;
    end else begin
      if (load_use) perf_ldu_stalls <= perf_ldu_stalls + 32'd1;
      if (mem_busy) perf_mem_stalls <= perf_mem_stalls + 32'd1;
      if (redirect) perf_flushes    <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RV32 core.
- Consumes decode-stage register usage, EX/MEM/WB destination info, branch/jump resolution and the data-memory handshake.
- Drives per-stage stall/flush/bubble controls and EX operand forwarding selects.
- Small FSM tracks memory wait (with timeout) and multi-cycle redirect flush.

Parameters:
- REDIRECT_PENALTY, 1, total cycles IF/ID is flushed after a taken redirect (legal 1..7).
- MEM_TIMEOUT, 255, memory wait cycles before mem_timeout is raised (legal 1..65535).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- dec_valid  in  1  ID holds a valid instruction.
- dec_rs1, dec_rs2  in  5 each  ID source registers.
- dec_use_rs1, dec_use_rs2  in  1 each  ID instruction actually reads that source.
- ex_valid  in  1  EX holds a valid instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- ex_rs1, ex_rs2  in  5 each  EX source registers (forwarding).
- ex_redirect  in  1  branch taken / jal / jalr resolved in EX.
- mem_reg_write  in  1  MEM instruction writes rd.
- mem_rd  in  5  MEM destination register.
- mem_req  in  1  MEM stage has an outstanding data access.
- mem_ready  in  1  data memory completes the access this cycle.
- wb_reg_write  in  1  WB writes rd.
- wb_rd  in  5  WB destination register.
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold the corresponding pipeline register.
- id_flush  out  1  load NOP into IF/ID.
- ex_bubble  out  1  load NOP into ID/EX.
- fwd_a_sel, fwd_b_sel  out  2 each  00 regfile, 01 MEM result, 10 WB data.
- mem_timeout  out  1  sticky: memory wait exceeded MEM_TIMEOUT.

Behaviour:
- Reset (rst=0, async): state=RUN, wait counter=0, redirect counter=0, mem_timeout=0. All stall/flush/bubble outputs depend only on inputs and state; with all valid/req inputs low they are 0.
- States: RUN, MEM_WAIT, REDIRECT.
- mem_busy = mem_req & ~mem_ready. While mem_busy, in any state:
  - All four stalls = 1; id_flush = ex_bubble = 0.
  - ex_redirect and load-use are ignored, because EX is frozen.
  - State goes to MEM_WAIT; the prior state is remembered for return.
- MEM_WAIT:
  - Wait counter increments each busy cycle, saturating at MEM_TIMEOUT.
  - On reaching MEM_TIMEOUT, mem_timeout sets and stays 1 until reset; stalls continue.
  - In the first cycle mem_ready=1, stalls drop in that same cycle. The counter clears, and next state is the saved state (RUN or REDIRECT, with the redirect count preserved).
- Redirect (not mem_busy, ex_valid & ex_redirect):
  - id_flush = 1 and ex_bubble = 1 in that cycle; stalls = 0.
  - If REDIRECT_PENALTY > 1, enter REDIRECT for REDIRECT_PENALTY-1 cycles with id_flush = 1, then return to RUN.
  - A new ex_redirect while in REDIRECT reloads the counter.
- Load-use (not mem_busy, no redirect, state RUN): ex_valid & ex_is_load & ex_rd!=0 & dec_valid & ((dec_use_rs1 & dec_rs1==ex_rd) | (dec_use_rs2 & dec_rs2==ex_rd)).
  - Response: if_stall = id_stall = 1 and ex_bubble = 1 for that cycle only.
  - ex_stall = mem_stall = 0.
- Priority: mem_busy > redirect > REDIRECT state flush > load-use. Load-use during REDIRECT is suppressed because the ID instruction is being flushed.
- Forwarding (combinational, independent of state), fwd_a_sel shown; fwd_b_sel is identical using ex_rs2:
  - 01 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1.
  - Else 10 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1.
  - Else 00.
  - MEM has priority over WB; x0 is never forwarded.
- Reset asserted mid-wait or mid-redirect: immediate return to RUN and counters cleared. mem_timeout clears only on reset.

Optional Feature:
- Macro HAZARD_PERF_EN. When defined, three added outputs, each 32 bits wide:
  - perf_ldu_stalls: load-use cycles.
  - perf_mem_stalls: mem_busy cycles.
  - perf_flushes: redirect events.
- All three counters reset to 0 and wrap modulo 2^32.
- Without the macro these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Load-use: ex_valid=1, ex_is_load=1, ex_rd=5, dec_valid=1, dec_use_rs1=1, dec_rs1=5 -> if_stall=id_stall=ex_bubble=1 for exactly 1 cycle; same with ex_rd=0 -> no stall.
- Forwarding: mem_reg_write=1, mem_rd=7, wb_reg_write=1, wb_rd=7, ex_rs1=7 -> fwd_a_sel=01; mem_reg_write=0 -> 10; ex_rs2=0 with wb_rd=0 -> fwd_b_sel=00.
- Redirect, REDIRECT_PENALTY=3: ex_redirect pulse -> id_flush=1 for 3 consecutive cycles, ex_bubble=1 in the first cycle only, then RUN.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles then 1 -> all stalls=1 for 4 cycles, 0 on the ready cycle; ex_redirect held during wait causes no flush until released.
- Timeout, MEM_TIMEOUT=8: mem_req=1, mem_ready=0 for 10 cycles -> mem_timeout rises after the 8th wait cycle, stays 1 after mem_ready; clears only on rst=0.
- Reset mid-REDIRECT: assert rst=0 during penalty cycle 2 -> id_flush=0, state RUN; after release, a load-use is detected normally.
